bus_arbiter: RTL and testbench

Two-master, three-slave arbiter and sequencer for the shared system bus. It grants the bus to master 1 or master 2 using round-robin arbitration and routes the winner's 2-bit slave select into a one-hot slave enable. It holds the grant until the transaction completes, the master drops its request, or a watchdog expires. It sits between the master ports and the bus datapath, and all datapath mux selects are driven from its registered outputs.

---
 rtl/bus_arbiter_pkg.sv | 34 +++
 rtl/bus_arbiter_rr.sv | 24 ++
 rtl/bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master, three-slave system bus arbiter:
// FSM states, master codes, slave ids and the slave-select decode.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SLAVE = 2'd1,
        GRANT      = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    typedef enum logic {
        MASTER_M1 = 1'b0,
        MASTER_M2 = 1'b1
    } master_t;

    localparam logic [1:0] SLAVE_NONE = 2'd0;
    localparam logic [1:0] SLAVE_1    = 2'd1;
    localparam logic [1:0] SLAVE_2    = 2'd2;
    localparam logic [1:0] SLAVE_3    = 2'd3;

    // Slave id 0 is the invalid select and decodes to no enable at all.
    function automatic logic [2:0] slave_onehot(input logic [1:0] sel);
        logic [2:0] en;
        case (sel)
            SLAVE_1: en = 3'b001;
            SLAVE_2: en = 3'b010;
            SLAVE_3: en = 3'b100;
            default: en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// on a tie the master that was not granted last wins.
module rr_arbiter2
    import bus_arbiter_pkg::*;
(
    input  logic    req_m1,
    input  logic    req_m2,
    input  master_t last_grant,
    output logic    any_req,
    output master_t winner
);

    always_comb begin
        any_req = req_m1 | req_m2;
        if (req_m1 && req_m2) begin
            winner = (last_grant == MASTER_M1) ? MASTER_M2 : MASTER_M1;
        end else if (req_m2) begin
            winner = MASTER_M2;
        end else begin
            winner = MASTER_M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter and sequencer: round-robin grant, slave-ready wait,
// one-cycle turnaround and a saturating watchdog; every output is registered.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_m1,
    input  logic       req_m2,
    input  logic [1:0] slave_select_input_m1,
    input  logic [1:0] slave_select_input_m2,
    input  logic [2:0] slave_ready,
    input  logic       xfer_done,
    output logic       grant_m1,
    output logic       grant_m2,
    output logic       master_sel,
    output logic [2:0] slave_en,
    output logic       timeout,
    output logic       sel_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    master_t          master_q, master_d;
    master_t          last_q, last_d;
    master_t          winner;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             any_req, win_req, target_ready, winner_sel_ok;
    logic [1:0]       winner_sel;
    logic             timeout_d, sel_err_d, grant_m1_d, grant_m2_d;
    logic [2:0]       slave_en_d;

    rr_arbiter2 u_rr (
        .req_m1     (req_m1),
        .req_m2     (req_m2),
        .last_grant (last_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign winner_sel    = (winner == MASTER_M1) ? slave_select_input_m1 : slave_select_input_m2;
    assign winner_sel_ok = (winner_sel != SLAVE_NONE);
    assign win_req       = (master_q == MASTER_M1) ? req_m1 : req_m2;
    assign target_ready  = |(slave_onehot(sel_q) & slave_ready);
    assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic; registered outputs are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        master_d  = master_q;
        last_d    = last_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        sel_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    master_d = winner;
                    sel_d    = winner_sel;
                    cnt_d    = '0;
                    if (!winner_sel_ok) begin
                        // Passing the turn on stops a bad master starving the other.
                        sel_err_d = 1'b1;
                        last_d    = winner;
                    end else begin
                        state_d = WAIT_SLAVE;
                    end
                end
            end
            WAIT_SLAVE: begin
                if (!win_req) begin
                    state_d = IDLE;
                end else if (target_ready) begin
                    state_d = GRANT;
                    last_d  = master_q;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GRANT: begin
                if (xfer_done || !win_req) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_m1_d = (state_d == GRANT) && (master_d == MASTER_M1);
        grant_m2_d = (state_d == GRANT) && (master_d == MASTER_M2);
        slave_en_d = (state_d == GRANT) ? slave_onehot(sel_d) : 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            master_q <= MASTER_M1;
            last_q   <= MASTER_M2;
            sel_q    <= SLAVE_NONE;
            cnt_q    <= '0;
            grant_m1 <= 1'b0;
            grant_m2 <= 1'b0;
            slave_en <= 3'b000;
            timeout  <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            grant_m1 <= grant_m1_d;
            grant_m2 <= grant_m2_d;
            slave_en <= slave_en_d;
            timeout  <= timeout_d;
            sel_err  <= sel_err_d;
        end
    end

    assign master_sel = master_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios push expected grant,
// timeout and sel_err events; a negedge monitor pops and compares them.
module tb_bus_arbiter;

    localparam logic [1:0] EV_GRANT   = 2'd0;
    localparam logic [1:0] EV_TIMEOUT = 2'd1;
    localparam logic [1:0] EV_SELERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       master;
        logic [2:0] slave_en;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_m1, req_m2;
    logic [1:0] slave_select_input_m1, slave_select_input_m2;
    logic [2:0] slave_ready;
    logic       xfer_done;
    logic       grant_m1, grant_m2, master_sel, timeout, sel_err;
    logic [2:0] slave_en;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];
    logic prev_m1 = 1'b0;
    logic prev_m2 = 1'b0;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_m1                (req_m1),
        .req_m2                (req_m2),
        .slave_select_input_m1 (slave_select_input_m1),
        .slave_select_input_m2 (slave_select_input_m2),
        .slave_ready           (slave_ready),
        .xfer_done             (xfer_done),
        .grant_m1              (grant_m1),
        .grant_m2              (grant_m2),
        .master_sel            (master_sel),
        .slave_en              (slave_en),
        .timeout               (timeout),
        .sel_err               (sel_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r1, input logic r2, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic [2:0] rdy);
        req_m1 = r1;
        req_m2 = r2;
        slave_select_input_m1 = s1;
        slave_select_input_m2 = s2;
        slave_ready = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input logic [1:0] kind, input logic master,
                               input logic [2:0] en);
        exp_t e;
        e.kind = kind;
        e.master = master;
        e.slave_en = en;
        sb_q.push_back(e);
    endtask

    task automatic scoreEvent(input logic [1:0] kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected event: got kind %0d, expected none", kind);
        end else begin
            e = sb_q.pop_front();
            checkOutput("event kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_GRANT) begin
                checkOutput("granted master", 32'(grant_m2), 32'(e.master));
                checkOutput("master_sel at grant", 32'(master_sel), 32'(e.master));
                checkOutput("slave_en at grant", 32'(slave_en), 32'(e.slave_en));
            end
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each output event.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("mutex", 32'(grant_m1 & grant_m2), 0);
            checkOutput("pulse exclusive", 32'(timeout & sel_err), 0);
            checkOutput("slave_en only with grant", 32'(slave_en != 3'b000),
                        32'(grant_m1 | grant_m2));
            checkOutput("turnaround", 32'((prev_m1 & grant_m2) | (prev_m2 & grant_m1)), 0);
            if (sel_err) scoreEvent(EV_SELERR);
            if (timeout) scoreEvent(EV_TIMEOUT);
            if ((grant_m1 | grant_m2) && !(prev_m1 | prev_m2)) scoreEvent(EV_GRANT);
            prev_m1 = grant_m1;
            prev_m2 = grant_m2;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global time limit: got no finish, expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int waited;
        reset = 1'b1;
        xfer_done = 1'b0;
        applyStimulus(0, 0, 2'd0, 2'd0, 3'b000);
        tick(2);
        checkOutput("reset grant_m1", 32'(grant_m1), 0);
        checkOutput("reset grant_m2", 32'(grant_m2), 0);
        checkOutput("reset master_sel", 32'(master_sel), 0);
        checkOutput("reset slave_en", 32'(slave_en), 0);
        checkOutput("reset timeout", 32'(timeout), 0);
        checkOutput("reset sel_err", 32'(sel_err), 0);
        reset = 1'b0;
        tick(1);

        // Single request from m1 to slave 2.
        expectEvent(EV_GRANT, 1'b0, 3'b010);
        applyStimulus(1, 0, 2'd2, 2'd0, 3'b111);
        tick(1);
        checkOutput("single: no grant after 1", 32'(grant_m1), 0);
        tick(1);
        checkOutput("single: grant_m1 after 2", 32'(grant_m1), 1);
        checkOutput("single: slave_en", 32'(slave_en), 32'h2);
        checkOutput("single: master_sel", 32'(master_sel), 0);
        xfer_done = 1'b1;
        tick(1);
        xfer_done = 1'b0;
        req_m1 = 1'b0;
        checkOutput("single: grant drops on xfer_done", 32'(grant_m1), 0);
        checkOutput("single: slave_en off in release", 32'(slave_en), 0);
        tick(1);

        // Tie: last grant was m1, so m2 goes first, then strict alternation.
        expectEvent(EV_GRANT, 1'b1, 3'b100);
        expectEvent(EV_GRANT, 1'b0, 3'b010);
        expectEvent(EV_GRANT, 1'b1, 3'b100);
        expectEvent(EV_GRANT, 1'b0, 3'b010);
        applyStimulus(1, 1, 2'd2, 2'd3, 3'b110);
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            while (!(grant_m1 || grant_m2) && waited < 12) begin
                tick(1);
                waited++;
            end
            checkOutput("tie: grant within bound", 32'(waited < 12), 1);
            tick(3);
            xfer_done = 1'b1;
            tick(1);
            xfer_done = 1'b0;
        end
        applyStimulus(0, 0, 2'd0, 2'd0, 3'b110);
        tick(1);

        // Slave 1 busy for five WAIT cycles, then ready.
        expectEvent(EV_GRANT, 1'b1, 3'b001);
        applyStimulus(0, 1, 2'd0, 2'd1, 3'b110);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("busy: no grant while slave busy", 32'(grant_m2), 0);
        end
        slave_ready = 3'b111;
        tick(1);
        checkOutput("busy: grant_m2 after ready", 32'(grant_m2), 1);
        checkOutput("busy: slave_en", 32'(slave_en), 32'h1);
        checkOutput("busy: master_sel", 32'(master_sel), 1);
        xfer_done = 1'b1;
        tick(1);
        xfer_done = 1'b0;
        req_m2 = 1'b0;
        tick(1);

        // Slave 3 never ready: watchdog fires after 8 WAIT cycles.
        expectEvent(EV_TIMEOUT, 1'b0, 3'b000);
        applyStimulus(1, 0, 2'd3, 2'd0, 3'b011);
        tick(8);
        checkOutput("wait timeout: not yet", 32'(timeout), 0);
        tick(1);
        checkOutput("wait timeout: pulse", 32'(timeout), 1);
        checkOutput("wait timeout: no grant", 32'(grant_m1), 0);
        req_m1 = 1'b0;
        tick(1);
        checkOutput("wait timeout: one cycle", 32'(timeout), 0);
        tick(1);

        // Invalid select from m1 (wins the tie), then m2 to slave 3.
        expectEvent(EV_SELERR, 1'b0, 3'b000);
        expectEvent(EV_GRANT, 1'b1, 3'b100);
        applyStimulus(1, 1, 2'd0, 2'd3, 3'b111);
        tick(1);
        checkOutput("sel_err: pulse", 32'(sel_err), 1);
        checkOutput("sel_err: no m1 grant", 32'(grant_m1), 0);
        tick(1);
        checkOutput("sel_err: one cycle", 32'(sel_err), 0);
        tick(1);
        checkOutput("sel_err: m2 granted", 32'(grant_m2), 1);
        checkOutput("sel_err: slave_en", 32'(slave_en), 32'h4);
        req_m1 = 1'b0;
        xfer_done = 1'b1;
        tick(1);
        xfer_done = 1'b0;
        req_m2 = 1'b0;
        checkOutput("release: master_sel holds", 32'(master_sel), 1);
        tick(1);

        // Grant held without xfer_done: watchdog releases after 8 GRANT cycles.
        expectEvent(EV_GRANT, 1'b0, 3'b001);
        expectEvent(EV_TIMEOUT, 1'b0, 3'b000);
        applyStimulus(1, 0, 2'd1, 2'd0, 3'b111);
        tick(2);
        checkOutput("grant wd: granted", 32'(grant_m1), 1);
        checkOutput("grant wd: master_sel", 32'(master_sel), 0);
        tick(7);
        checkOutput("grant wd: still held at 8th cycle", 32'(grant_m1), 1);
        tick(1);
        checkOutput("grant wd: dropped", 32'(grant_m1), 0);
        checkOutput("grant wd: timeout pulse", 32'(timeout), 1);
        req_m1 = 1'b0;
        tick(1);
        checkOutput("grant wd: timeout one cycle", 32'(timeout), 0);
        tick(1);

        // Asynchronous reset in the middle of a grant.
        expectEvent(EV_GRANT, 1'b0, 3'b010);
        applyStimulus(1, 0, 2'd2, 2'd0, 3'b111);
        tick(2);
        checkOutput("async: granted", 32'(grant_m1), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async: grant_m1 cleared", 32'(grant_m1), 0);
        checkOutput("async: slave_en cleared", 32'(slave_en), 0);
        applyStimulus(0, 0, 2'd0, 2'd0, 3'b111);
        tick(2);
        reset = 1'b0;
        tick(1);

        // First tie after reset goes to m1.
        expectEvent(EV_GRANT, 1'b0, 3'b001);
        applyStimulus(1, 1, 2'd1, 2'd2, 3'b111);
        tick(2);
        checkOutput("post-reset tie: m1", 32'(grant_m1), 1);
        checkOutput("post-reset tie: slave_en", 32'(slave_en), 32'h1);
        xfer_done = 1'b1;
        tick(1);
        xfer_done = 1'b0;
        applyStimulus(0, 0, 2'd0, 2'd0, 3'b111);
        tick(3);

        checkOutput("scoreboard drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
